// File: rtl/dmem_responder_if.sv
// dmem_responder_if
// Request/response bus between the core's load/store unit and the data
// memory responder.
//   req_valid/req_ready  : request handshake (master -> slave)
//   req_we               : 1 = store, 0 = load
//   req_funct3           : RV32I load/store funct3
//   req_addr             : byte address
//   req_wdata            : right-aligned store data
//   rsp_valid/rsp_ready  : response handshake (slave -> master)
//   rsp_rdata            : extended load result, 0 for stores/errors
//   rsp_err              : illegal access
// The master modport is the core side; the slave modport is the memory side.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory responder: accepts one RV32I load/store at a time, waits a
// fixed number of cycles, performs the access on an internal word array and
// returns the result over a valid/ready response handshake.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   bus   : dmem_responder_if.slave (request and response handshakes)
//   busy  : a request is in flight (FSM not idle)
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 4)
//   WAIT_STATES : wait cycles inserted between acceptance and response (0..15)
// Build option:
//   DMEM_MISALIGN_TRAP_EN : when defined, misaligned halfword/word accesses
//                           respond with rsp_err=1 and perform no write.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                rst,
    dmem_responder_if.slave     bus,
    output logic                busy
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [3:0]    cnt_reg;
    logic          we_reg;
    logic [2:0]    funct3_reg;
    logic [AW+1:0] addr_reg;
    logic [31:0]   wdata_reg;
    logic          req_ready_reg;
    logic          rsp_valid_reg;
    logic          rsp_err_reg;
    logic [31:0]   rsp_rdata_reg;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          resp_entry;
    logic          rsp_done;
    logic          illegal;
    logic          access_err;
    logic          mem_we;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   load_value;
    logic [3:0]    lane_en;
    logic [31:0]   wr_data;

    // Address bits above the array size are deliberately ignored (wrap).
    logic          unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[31:AW+2];

    assign accept     = (state_reg == ST_IDLE) && req_ready_reg && bus.req_valid;
    assign resp_entry = (state_reg == ST_WAIT) && (cnt_reg == 4'd0);
    assign rsp_done   = (state_reg == ST_RESP) && bus.rsp_ready;

    // The counter is loaded with WAIT_STATES on acceptance: one edge moves
    // into WAIT, then WAIT_STATES further edges elapse before RESP entry, so
    // rsp_valid rises WAIT_STATES+1 edges after the acceptance edge.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)     state_next = ST_WAIT;
            ST_WAIT: if (resp_entry) state_next = ST_RESP;
            ST_RESP: if (rsp_done)   state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // Decode of the latched request.
    assign illegal = we_reg ? (funct3_reg[2] || (funct3_reg[1:0] == 2'b11))
                            : ((funct3_reg[1:0] == 2'b11) || (funct3_reg == 3'b110));

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((funct3_reg[1:0] == 2'b01) && addr_reg[0]) ||
                        ((funct3_reg[1:0] == 2'b10) && (addr_reg[1:0] != 2'b00));
    assign access_err = illegal || misaligned;
`else
    assign access_err = illegal;
`endif

    assign word_idx = addr_reg[AW+1:2];
    assign rd_word  = mem[word_idx];
    assign ld_byte  = rd_word[{addr_reg[1:0], 3'b000} +: 8];
    assign ld_half  = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_value = '0;
        case (funct3_reg)
            3'b000:  load_value = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_value = {{16{ld_half[15]}}, ld_half};
            3'b010:  load_value = rd_word;
            3'b100:  load_value = {24'd0, ld_byte};
            3'b101:  load_value = {16'd0, ld_half};
            default: load_value = '0;
        endcase
    end

    // Store byte lanes: data is replicated across lanes so each lane only
    // needs its own enable.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_en[gi] = (funct3_reg[1:0] == 2'b10) ||
                                 ((funct3_reg[1:0] == 2'b01) && (addr_reg[1] == 1'(gi / 2))) ||
                                 ((funct3_reg[1:0] == 2'b00) && (addr_reg[1:0] == 2'(gi)));
            assign wr_data[gi*8 +: 8] = (funct3_reg[1:0] == 2'b00) ? wdata_reg[7:0] :
                                        (funct3_reg[1:0] == 2'b01) ? wdata_reg[(gi % 2)*8 +: 8] :
                                                                     wdata_reg[gi*8 +: 8];
        end
    endgenerate

    // A store commits only on its RESP-entry edge; a reset before that edge
    // returns the FSM to IDLE so the write never happens.
    assign mem_we = resp_entry && we_reg && !access_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    mem[word_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            we_reg        <= 1'b0;
            funct3_reg    <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            req_ready_reg <= (state_next == ST_IDLE);

            if (accept) begin
                we_reg     <= bus.req_we;
                funct3_reg <= bus.req_funct3;
                addr_reg   <= bus.req_addr[AW+1:0];
                wdata_reg  <= bus.req_wdata;
                cnt_reg    <= 4'(WAIT_STATES);
            end else if ((state_reg == ST_WAIT) && (cnt_reg != 4'd0)) begin
                cnt_reg <= cnt_reg - 4'd1;
            end

            if (resp_entry) begin
                rsp_valid_reg <= 1'b1;
                rsp_err_reg   <= access_err;
                rsp_rdata_reg <= (we_reg || access_err) ? 32'd0 : load_value;
            end else if (rsp_done) begin
                rsp_valid_reg <= 1'b0;
                rsp_err_reg   <= 1'b0;
                rsp_rdata_reg <= '0;
            end
        end
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign busy          = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Self-checking bench for dmem_responder: directed scenarios followed by a
// randomized run checked against a byte-addressed reference memory.
module tb_dmem_responder;
    localparam int DEPTH = 256;
    localparam int WS    = 1;
    localparam int LAT   = WS + 1;   // acceptance edge -> edge raising rsp_valid

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] mem_m [4*DEPTH];

    dmem_responder_if bus();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: byte-addressed memory with RV32I access rules.
    function automatic void model_access(input logic we, input logic [2:0] f3,
                                         input logic [31:0] addr, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic er);
        int a, nbytes, base;
        logic legal, mis;
        logic [31:0] val;
        a      = int'(addr % (4 * DEPTH));
        legal  = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        nbytes = 1 << f3[1:0];
        base   = a - (a % nbytes);
        mis    = (a % nbytes) != 0;
        er     = !legal;
`ifdef DMEM_MISALIGN_TRAP_EN
        er     = er || mis;
`endif
        rd = 32'd0;
        if (er) return;
        if (we) begin
            for (int k = 0; k < nbytes; k++) mem_m[base + k] = wd[8*k +: 8];
        end else begin
            val = 32'd0;
            for (int k = 0; k < nbytes; k++) val = val | (32'(mem_m[base + k]) << (8 * k));
            if (!f3[2] && nbytes < 4 && val[8*nbytes-1]) val = val | (32'hFFFF_FFFF << (8 * nbytes));
            rd = val;
        end
    endfunction

    // Drives one request, measures latency, optionally stalls the response.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int stall,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        rd = 32'd0; er = 1'b0; lat = -1;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.rsp_ready  = (stall == 0);
        n = 0;
        while (bus.req_ready !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL accept_timeout: req_ready=%b required 1", bus.req_ready);
                bus.req_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);                    // acceptance edge has passed
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.rsp_valid !== 1'b1) begin
            @(negedge clk);
            lat++;
            if (lat > 40) begin
                checks++; errors++;
                $display("FAIL rsp_timeout: rsp_valid=%b required 1", bus.rsp_valid);
                bus.rsp_ready = 1'b1;
                return;
            end
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        repeat (stall) @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(negedge clk);                    // handshake edge has passed
        $display("xact we=%0d f3=%0d addr=%h wdata=%h stall=%0d -> rdata=%h err=%0b lat=%0d",
                 we, f3, addr, wd, stall, rd, er, lat);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b required 0", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata: got %h required 0", bus.rsp_rdata); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b required 0", bus.rsp_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b required 1", bus.req_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL sw_latency: got %0d required %0d", lat, LAT); end
        checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL sw_rsp: got err=%b rdata=%h required 0/0", er, rd); end
        xact(1'b0, 3'b010, 32'h10, 32'd0, 0, rd, er, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL lw_latency: got %0d required %0d", lat, LAT); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h required deadbeef", rd); end
        xact(1'b1, 3'b000, 32'h12, 32'h55, 0, rd, er, lat);
        xact(1'b0, 3'b010, 32'h10, 32'd0, 0, rd, er, lat);
        checks++; if (rd !== 32'hDE55BEEF) begin errors++; $display("FAIL sb_lane: got %h required de55beef", rd); end
        xact(1'b0, 3'b000, 32'h13, 32'd0, 0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb_sext: got %h required ffffffde", rd); end
        xact(1'b0, 3'b100, 32'h13, 32'd0, 0, rd, er, lat);
        checks++; if (rd !== 32'h000000DE) begin errors++; $display("FAIL lbu_zext: got %h required 000000de", rd); end
        xact(1'b0, 3'b001, 32'h12, 32'd0, 0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFDE55) begin errors++; $display("FAIL lh_sext: got %h required ffffde55", rd); end
        xact(1'b0, 3'b101, 32'h12, 32'd0, 0, rd, er, lat);
        checks++; if (rd !== 32'h0000DE55) begin errors++; $display("FAIL lhu_zext: got %h required 0000de55", rd); end
        xact(1'b1, 3'b010, 32'h20, 32'h12345678, 0, rd, er, lat);
    endtask

    task automatic test_illegal();
        logic [31:0] rd; logic er; int lat;
        xact(1'b0, 3'b011, 32'h0, 32'd0, 0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL illegal_load: got err=%b rdata=%h required 1/0", er, rd); end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL illegal_latency: got %0d required %0d", lat, LAT); end
        xact(1'b1, 3'b111, 32'h10, 32'h0, 0, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL illegal_store_err: got %b required 1", er); end
        xact(1'b0, 3'b010, 32'h10, 32'd0, 0, rd, er, lat);
        checks++; if (rd !== 32'hDE55BEEF) begin errors++; $display("FAIL illegal_store_nowrite: got %h required de55beef", rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er; int lat;
        xact(1'b0, 3'b010, 32'h11, 32'd0, 0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL misalign_trap: got err=%b rdata=%h required 1/0", er, rd); end
`else
        checks++; if (er !== 1'b0 || rd !== 32'hDE55BEEF) begin errors++; $display("FAIL misalign_ignore: got err=%b rdata=%h required 0/de55beef", er, rd); end
`endif
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 3'b010, 32'(4 * DEPTH), 32'h1, 0, rd, er, lat);
        xact(1'b0, 3'b010, 32'h0, 32'd0, 0, rd, er, lat);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL addr_wrap: got %h required 00000001", rd); end
    endtask

    task automatic test_stall();
        logic [31:0] r0; int n; logic [31:0] rd; logic er; int lat;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h10; bus.req_wdata = 32'd0; bus.rsp_ready = 1'b0;
        @(negedge clk);                    // accepted (responder idle)
        // pending request held valid with different fields throughout RESP
        bus.req_we = 1'b1; bus.req_addr = 32'h30; bus.req_wdata = 32'hCAFEF00D;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        r0 = bus.rsp_rdata;
        checks++; if (r0 !== 32'hDE55BEEF) begin errors++; $display("FAIL stall_data: got %h required de55beef", r0); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== r0 || bus.req_ready !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL stall_hold: valid=%b rdata=%h req_ready=%b busy=%b required 1/%h/0/1",
                                   bus.rsp_valid, bus.rsp_rdata, bus.req_ready, busy, r0);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);                    // handshake edge
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL stall_release: valid=%b req_ready=%b busy=%b required 0/1/0", bus.rsp_valid, bus.req_ready, busy);
        end
        @(negedge clk);                    // pending request accepted here
        bus.req_valid = 1'b0;
        checks++; if (busy !== 1'b1 || bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: busy=%b req_ready=%b required 1/0", busy, bus.req_ready);
        end
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        xact(1'b0, 3'b010, 32'h30, 32'd0, 0, rd, er, lat);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_store: got %h required cafef00d", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h20; bus.req_wdata = 32'hA5A5A5A5; bus.rsp_ready = 1'b1;
        @(negedge clk);                    // accepted, now in WAIT
        bus.req_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b required 1", busy); end
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: busy=%b req_ready=%b valid=%b rdata=%h err=%b required all 0",
                               busy, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_held: busy=%b req_ready=%b valid=%b required 0/0/0", busy, bus.req_ready, bus.rsp_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        xact(1'b0, 3'b010, 32'h20, 32'd0, 0, rd, er, lat);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL midrst_discard: got %h required 12345678", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, wd, addr; logic er, eer, we; logic [2:0] f3; int lat, stall;
        for (int i = 0; i < DEPTH; i++) begin
            wd = $urandom;
            model_access(1'b1, 3'b010, 32'(i * 4), wd, erd, eer);
            xact(1'b1, 3'b010, 32'(i * 4), wd, 0, rd, er, lat);
            checks++; if (er !== 1'b0) begin errors++; $display("FAIL fill_err: word %0d got %b required 0", i, er); end
        end
        for (int i = 0; i < 200; i++) begin
            we    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            addr  = 32'($urandom_range(0, 8 * DEPTH - 1));
            wd    = $urandom;
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            model_access(we, f3, addr, wd, erd, eer);
            xact(we, f3, addr, wd, stall, rd, er, lat);
            checks++; if (rd !== erd) begin errors++; $display("FAIL rand_rdata[%0d]: got %h required %h", i, rd, erd); end
            checks++; if (er !== eer) begin errors++; $display("FAIL rand_err[%0d]: got %b required %b", i, er, eer); end
            checks++; if (lat !== LAT) begin errors++; $display("FAIL rand_latency[%0d]: got %0d required %0d", i, lat, LAT); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_misalign();
        test_wrap();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
